// File: rtl/hsst2ad_rd_pkg.sv
// hsst2ad_rd_pkg: shared types and constants for the hsst2ad FIFO read-side
// drain engine.
//   rd_state_t      : drain FSM state encoding (IDLE / RUN / FLUSH)
//   DFLT_DATA_WIDTH : default FIFO read data width
//   CHK_SEED        : first value of the descending-count pattern
//   CHK_SAT_RELOAD  : value the 3-bit error counter reloads once it reaches 7
package hsst2ad_rd_pkg;

  localparam int DFLT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

  localparam logic [7:0] CHK_SEED       = 8'hFF;
  localparam logic [2:0] CHK_SAT_RELOAD = 3'b100;

endpackage

// File: rtl/hsst2ad_rd_skid.sv
// hsst2ad_rd_skid: circular skid buffer that catches every read already in
// flight when the stream stalls.
//   clk, tb_rst   : clock, asynchronous active-high reset
//   clear         : drop all entries and rewind both pointers (wins over push/pop)
//   push/push_data: write one entry at the tail
//   pop           : consume the head entry
//   head          : current head entry
//   occ           : number of entries held
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module hsst2ad_rd_skid #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         occ
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/hsst2ad_fifo_reader.sv
// hsst2ad_fifo_reader: drains the hsst2ad async FIFO read port and presents
// the bytes as a valid/ready stream, compensating for the FIFO read latency
// (1 + OUTPUT_REG cycles) with a small skid buffer.
//   clk, tb_rst                 : read/stream clock, async active-high reset
//   fifo_rd_en/_data/_empty     : FIFO read port
//   flush                       : one-cycle request to discard all queued data
//   m_data/m_valid/m_ready      : output stream
//   busy                        : engine is in RUN or FLUSH
//   rd_count                    : stream handshakes, wraps at 2^16
//   chk_err/chk_err_cnt         : descending-pattern checker; only active
//                                 when HSST2AD_RD_CHECK_EN is defined,
//                                 otherwise tied to 0
//
// state | meaning
// IDLE  | FIFO empty, nothing buffered or in flight
// RUN   | issuing reads while buffer room remains, streaming buffer head
// FLUSH | reading FIFO to empty and dropping every returned byte
module hsst2ad_fifo_reader
  import hsst2ad_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DFLT_DATA_WIDTH,
  parameter int OUTPUT_REG = 0,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           rd_count,
  output logic                  chk_err,
  output logic [2:0]            chk_err_cnt
);

  localparam int LAT = 1 + OUTPUT_REG;
  localparam int CW  = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(BUF_DEPTH);

  rd_state_t      state_q, state_d;
  logic [LAT-1:0] tag_q;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  occ;
  logic           room;
  logic           enter_flush;
  logic           hs;
  logic           push;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(tag_q[i]);
  end

  // Reads in flight count against buffer space so a stall can never overrun it.
  assign room        = ({1'b0, occ} + {1'b0, inflight}) < DEPTH_C;
  assign enter_flush = flush && (state_q != ST_FLUSH);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_rd_empty) state_d = ST_RUN;
      ST_RUN:   if (fifo_rd_empty && inflight == '0 && occ == '0) state_d = ST_IDLE;
      ST_FLUSH: if (fifo_rd_empty && inflight == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (enter_flush) state_d = ST_FLUSH;
  end

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q  <= ST_IDLE;
      tag_q    <= '0;
      rd_count <= '0;
    end else begin
      state_q <= state_d;
      // Tag shifts toward the MSB; the MSB marks data valid on fifo_rd_data.
      tag_q   <= LAT'({tag_q, fifo_rd_en});
      if (hs) rd_count <= rd_count + 16'd1;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign fifo_rd_en = busy && !fifo_rd_empty && ((state_q == ST_FLUSH) || room);
  assign m_valid    = (occ != '0) && (state_q != ST_FLUSH);
  // A flush request in the same cycle cancels the handshake.
  assign hs         = m_valid && m_ready && !flush;
  assign push       = tag_q[LAT-1] && (state_q != ST_FLUSH);

  hsst2ad_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .clear     (enter_flush),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (hs),
    .head      (m_data),
    .occ       (occ)
  );

`ifdef HSST2AD_RD_CHECK_EN
  logic [7:0] chk_exp;
  logic       flush_exit;

  assign flush_exit = (state_q == ST_FLUSH) && (state_d == ST_IDLE);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      chk_exp     <= CHK_SEED;
      chk_err     <= 1'b0;
      chk_err_cnt <= '0;
    end else begin
      chk_err <= hs && (8'(m_data) != chk_exp);
      if (flush_exit)  chk_exp <= CHK_SEED;
      else if (hs)     chk_exp <= chk_exp - 8'd1;
      if (chk_err) chk_err_cnt <= (chk_err_cnt == 3'b111) ? CHK_SAT_RELOAD : chk_err_cnt + 3'd1;
    end
  end
`else
  assign chk_err     = 1'b0;
  assign chk_err_cnt = 3'b000;
`endif

endmodule

// File: tb/tb_hsst2ad_fifo_reader.sv
module tb_hsst2ad_fifo_reader;

  localparam int OREG  = 0;
  localparam int LAT   = 1 + OREG;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_empty;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic [15:0] rd_count;
  logic        chk_err;
  logic [2:0]  chk_err_cnt;

  hsst2ad_fifo_reader #(
    .DATA_WIDTH (8),
    .OUTPUT_REG (OREG),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .tb_rst        (tb_rst),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .flush         (flush),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .busy          (busy),
    .rd_count      (rd_count),
    .chk_err       (chk_err),
    .chk_err_cnt   (chk_err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pat = 8'hFF;
  int hs_cnt = 0, first_hs = -1, last_hs = -1;
  int issued = 0, delivered = 0, max_out = 0;
  bit bound_en = 0, lat_arm = 0, in_flush_chk = 0;
  int t_empty = -1, t_valid = -1;
  int chk_pulses = 0;
  int ready_mode = 0;
  int exp_rd = 0;
  int err_injected = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Behavioural FIFO read port with read latency LAT.
  initial begin
    logic [7:0] pipe [2];
    bit rd_s;
    pipe[0] = 8'h00;
    pipe[1] = 8'h00;
    fifo_rd_data  = 8'h00;
    fifo_rd_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_s = fifo_rd_en;
      @(posedge clk);
      #1;
      pipe[1] = pipe[0];
      pipe[0] = (rd_s && fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
      fifo_rd_data  = (LAT == 1) ? pipe[0] : pipe[1];
      fifo_rd_empty = (fifo_q.size() == 0);
    end
  end

  // Downstream ready pattern.
  initial begin
    int k = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        2:       m_ready = ($urandom_range(0, 1) == 1);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!tb_rst) begin
        int out_now;
        out_now = issued - delivered;
        if (fifo_rd_en) begin
          check("rd_en_while_empty", fifo_rd_empty, 0);
          if (bound_en) check("outstanding_below_depth", int'(out_now < DEPTH), 1);
          issued++;
        end
        if (out_now > max_out) max_out = out_now;
        if (lat_arm && !fifo_rd_empty && t_empty < 0) t_empty = cyc;
        if (lat_arm && m_valid && t_valid < 0) t_valid = cyc;
        if (in_flush_chk && busy) check("valid_during_flush", m_valid, 0);
        if (chk_err) chk_pulses++;
        if (m_valid && m_ready && !flush) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", int'(m_data), -1);
          end else begin
            check("stream_data", int'(m_data), int'(exp_q.pop_front()));
          end
          hs_cnt++;
          delivered++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < budget && !(exp_q.size() == 0 && fifo_q.size() == 0 && !busy));
    if (n >= budget) check({name, "_timeout"}, n, -1);
  endtask

  function automatic int exp_err_cnt(input int e);
    return (e <= 7) ? e : 4 + ((e - 8) % 4);
  endfunction

  initial begin
    int n, gap, wait_n;
    tb_rst = 1'b1;
    flush  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_m_data", m_data, 0);
    check("rst_chk_err_cnt", chk_err_cnt, 0);
    @(posedge clk); #1 tb_rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full-rate 256-byte burst.
    #1;
    ready_mode = 0; lat_arm = 1; t_empty = -1; t_valid = -1;
    hs_cnt = 0; first_hs = -1;
    for (int i = 0; i < 256; i++) begin push_byte(pat); pat = pat - 8'd1; end
    wait_idle(3000, "burst");
    lat_arm = 0;
    exp_rd += 256;
    check("first_valid_latency", t_valid - t_empty, LAT + 2);
    check("burst_handshakes", hs_cnt, 256);
    check("burst_full_rate_span", last_hs - first_hs, 255);
    check("burst_rd_count", rd_count, exp_rd);

    // 1-of-3 back-pressure: reads stall once outstanding reaches DEPTH.
    @(posedge clk); #1;
    ready_mode = 1; issued = 0; delivered = 0; max_out = 0; bound_en = 1; hs_cnt = 0;
    for (int i = 0; i < 256; i++) begin push_byte(pat); pat = pat - 8'd1; end
    wait_idle(5000, "stall");
    bound_en = 0;
    exp_rd += 256;
    check("stall_max_outstanding", max_out, DEPTH);
    check("stall_handshakes", hs_cnt, 256);
    check("stall_rd_count", rd_count, exp_rd);

    // Flush after 10 bytes, with m_ready high in the flush cycle.
    @(posedge clk); #1;
    ready_mode = 0; hs_cnt = 0;
    for (int i = 0; i < 256; i++) begin push_byte(pat); pat = pat - 8'd1; end
    wait_n = 0;
    while (hs_cnt < 10 && wait_n < 1000) begin @(negedge clk); wait_n++; end
    if (wait_n >= 1000) check("flush_wait_timeout", wait_n, -1);
    @(posedge clk); #1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    in_flush_chk = 1;
    @(negedge clk);
    check("busy_in_flush", busy, 1);
    wait_idle(3000, "flush_drain");
    in_flush_chk = 0;
    exp_rd += 10;
    pat = 8'hFF;
    check("flush_handshakes", hs_cnt, 10);
    check("flush_rd_count", rd_count, exp_rd);
    check("flush_idle_busy", busy, 0);

    // Random bursts with random back-pressure, pattern continues.
    @(posedge clk); #1;
    ready_mode = 2;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin push_byte(pat); pat = pat - 8'd1; end
      exp_rd += n;
      gap = $urandom_range(0, 20);
      repeat (gap) @(posedge clk);
      #1;
    end
    wait_idle(5000, "random");
    check("random_rd_count", rd_count, exp_rd);

    // Pattern checker: one corrupted byte, then seven more.
    @(posedge clk); #1;
    ready_mode = 0; chk_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      if (pat == 8'h80) begin push_byte(8'h81); err_injected++; end
      else push_byte(pat);
      pat = pat - 8'd1;
    end
    wait_idle(3000, "corrupt1");
    repeat (3) @(negedge clk);
    exp_rd += 256;
`ifdef HSST2AD_RD_CHECK_EN
    check("chk_single_pulses", chk_pulses, err_injected);
    check("chk_single_cnt", chk_err_cnt, exp_err_cnt(err_injected));
`endif
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) begin
      if (i % 9 == 2 && i < 63) begin push_byte(pat ^ 8'h01); err_injected++; end
      else push_byte(pat);
      pat = pat - 8'd1;
    end
    wait_idle(3000, "corrupt7");
    repeat (3) @(negedge clk);
    exp_rd += 64;
`ifdef HSST2AD_RD_CHECK_EN
    check("chk_multi_pulses", chk_pulses, err_injected);
    check("chk_multi_cnt", chk_err_cnt, exp_err_cnt(err_injected));
`else
    check("chk_tied_pulses", chk_pulses, 0);
    check("chk_tied_cnt", chk_err_cnt, 0);
`endif
    check("checker_rd_count", rd_count, exp_rd);

    // Asynchronous reset in the middle of a burst.
    @(posedge clk); #1;
    ready_mode = 0; hs_cnt = 0;
    for (int i = 0; i < 256; i++) begin push_byte(pat); pat = pat - 8'd1; end
    wait_n = 0;
    while (!(hs_cnt >= 20 && m_valid) && wait_n < 1000) begin @(negedge clk); wait_n++; end
    if (wait_n >= 1000) check("reset_wait_timeout", wait_n, -1);
    check("pre_reset_valid", m_valid, 1);
    @(posedge clk); #2;
    tb_rst = 1'b1;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_rd_count", rd_count, 0);
    check("arst_m_data", m_data, 0);
    fifo_q.delete();
    exp_q.delete();
    pat = 8'hFF;
    exp_rd = 0;
    repeat (2) @(posedge clk);
    #1 tb_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", busy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin push_byte(pat); pat = pat - 8'd1; end
    wait_idle(1000, "post_reset");
    exp_rd += 16;
    check("post_reset_rd_count", rd_count, exp_rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
